// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> (MEM) -> WB.
// Steers the instruction fetch handshake, the data memory handshake, the
// register-file write and the PC update, and holds the architectural NZCV
// flags in cpsr.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   stall                 external hold, only looked at in FETCH
//   imem_req / imem_ack   instruction fetch handshake
//   ir_load               instruction-register load, same cycle as the ack
//   op_flags[6:0]         decoded flags {ret,call,str,ld,jmp,cmp,alu}
//   taken                 condition result for the current instruction
//   nzcv_in[3:0]          comparator flags, captured by cmp
//   cpsr[31:0]            {28'd0, nzcv}
//   dmem_req / dmem_we / dmem_ack   data memory handshake
//   reg_we, reg_wsel[1:0] register write enable and source (0 ALU, 1 load)
//   pc_we, pc_sel[1:0]    PC update strobe and source (0 PC+1, 1 target,
//                         RET_SEL return data)
//   retired               one pulse per completed instruction
//   state[2:0]            current FSM state, for debug
// ---------------------------------------------------------------------------
module core_sequencer #(
  parameter logic [1:0] RET_SEL = 2'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic [6:0]  op_flags,
  input  logic        taken,
  input  logic [3:0]  nzcv_in,
  output logic [31:0] cpsr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic [1:0]  reg_wsel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_ALU, OP_CMP, OP_JMP, OP_LD, OP_STR, OP_CALL, OP_RET
  } op_t;

  // Write-back controls, packed so they can be loaded in one assignment.
  typedef struct packed {
    logic       reg_we;
    logic [1:0] reg_wsel;
    logic [1:0] pc_sel;
  } wb_ctl_t;

  state_t     state_q;
  op_t        op_q;
  op_t        op_next;
  logic       taken_q;
  logic [3:0] nzcv_q;
  logic       run_q;   // low in reset and for the first cycle after it

  // Highest-priority flag wins; everything below it is ignored.
  function automatic op_t resolve_op(input logic [6:0] f);
    if      (f[6]) return OP_RET;
    else if (f[5]) return OP_CALL;
    else if (f[4]) return OP_STR;
    else if (f[3]) return OP_LD;
    else if (f[2]) return OP_JMP;
    else if (f[1]) return OP_CMP;
    else if (f[0]) return OP_ALU;
    else           return OP_NOP;
  endfunction

  function automatic logic is_mem(input op_t op);
    return (op == OP_LD) || (op == OP_STR) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  function automatic logic is_write(input op_t op);
    return (op == OP_STR) || (op == OP_CALL);
  endfunction

  function automatic wb_ctl_t wb_ctl(input op_t op, input logic tk);
    wb_ctl_t c;
    c = '0;
    case (op)
      OP_ALU:  c.reg_we = 1'b1;
      OP_LD:   begin c.reg_we = 1'b1; c.reg_wsel = 2'd1; end
      OP_CALL: c.pc_sel = 2'd1;
      OP_JMP:  c.pc_sel = tk ? 2'd1 : 2'd0;
      OP_RET:  c.pc_sel = RET_SEL;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_next = resolve_op(op_flags);

  // The fetch handshake has to react in the same cycle as stall and
  // imem_ack, so these two are decoded rather than registered. run_q keeps
  // them low while reset is asserted and until the first edge after it.
  assign imem_req = run_q && (state_q == FETCH) && !stall;
  assign ir_load  = imem_req && imem_ack;

  assign cpsr  = {28'd0, nzcv_q};
  assign state = state_q;

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, whatever order they are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      op_q     <= OP_NOP;
      taken_q  <= 1'b0;
      nzcv_q   <= 4'd0;
      run_q    <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      reg_we   <= 1'b0;
      reg_wsel <= 2'd0;
      pc_we    <= 1'b0;
      pc_sel   <= 2'd0;
      retired  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      // Write-back strobes last exactly one cycle unless re-entered below.
      pc_we    <= 1'b0;
      retired  <= 1'b0;
      reg_we   <= 1'b0;
      reg_wsel <= 2'd0;
      pc_sel   <= 2'd0;

      case (state_q)
        FETCH: begin
          if (ir_load) state_q <= DECODE;
        end
        DECODE: begin
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          op_q    <= op_next;
          taken_q <= taken;
          if (op_next == OP_CMP) nzcv_q <= nzcv_in;
          if (is_mem(op_next)) begin
            state_q  <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= is_write(op_next);
          end else begin
            state_q <= WB;
            {reg_we, reg_wsel, pc_sel} <= wb_ctl(op_next, taken);
            pc_we   <= 1'b1;
            retired <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state_q  <= WB;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            {reg_we, reg_wsel, pc_sel} <= wb_ctl(op_q, taken_q);
            pc_we   <= 1'b1;
            retired <= 1'b1;
          end
        end
        WB: begin
          state_q <= FETCH;
        end
        default: begin
          // Unused encodings recover to FETCH with the data port idle.
          state_q  <= FETCH;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
// Directed bench for core_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are sampled a further time unit later.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_load;
  logic [6:0]  op_flags;
  logic        taken;
  logic [3:0]  nzcv_in;
  logic [31:0] cpsr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        reg_we;
  logic [1:0]  reg_wsel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        retired;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;

  core_sequencer #(.RET_SEL(2'd2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .ir_load  (ir_load),
    .op_flags (op_flags),
    .taken    (taken),
    .nzcv_in  (nzcv_in),
    .cpsr     (cpsr),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .reg_we   (reg_we),
    .reg_wsel (reg_wsel),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .retired  (retired),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (retired) retire_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from FETCH with imem_req already high.
  task automatic do_instr(input string tag, input logic [6:0] flags, input logic tk,
                          input logic [3:0] nz, input int wait_cyc,
                          input logic exp_mem, input logic exp_dwe,
                          input logic exp_rwe, input logic [1:0] exp_wsel,
                          input logic [1:0] exp_psel, input logic [31:0] exp_cpsr);
    int n_req;
    imem_ack = 1'b1;
    op_flags = flags;
    taken    = tk;
    nzcv_in  = nz;
    #1;
    check({tag, "_fetch_state"}, state, 0);
    check({tag, "_ir_load"}, ir_load, 1);
    tick();
    imem_ack = 1'b0;
    check({tag, "_decode_state"}, state, 1);
    check({tag, "_decode_ir_load"}, ir_load, 0);
    tick();
    check({tag, "_exec_state"}, state, 2);
    check({tag, "_exec_retired"}, retired, 0);
    check({tag, "_exec_pc_sel"}, pc_sel, 0);
    tick();
    if (exp_mem) begin
      check({tag, "_mem_state"}, state, 3);
      check({tag, "_mem_dmem_we"}, dmem_we, exp_dwe);
      n_req = 0;
      for (int i = 0; i <= wait_cyc; i++) begin
        if (i == wait_cyc) dmem_ack = 1'b1;
        #1;
        if (dmem_req) n_req++;
        tick();
      end
      dmem_ack = 1'b0;
      check({tag, "_dmem_req_cycles"}, n_req, wait_cyc + 1);
    end
    check({tag, "_wb_state"}, state, 4);
    check({tag, "_wb_pc_we"}, pc_we, 1);
    check({tag, "_wb_retired"}, retired, 1);
    check({tag, "_wb_reg_we"}, reg_we, exp_rwe);
    check({tag, "_wb_reg_wsel"}, reg_wsel, exp_wsel);
    check({tag, "_wb_pc_sel"}, pc_sel, exp_psel);
    check({tag, "_wb_dmem_req"}, dmem_req, 0);
    check({tag, "_wb_dmem_we"}, dmem_we, 0);
    check({tag, "_wb_cpsr"}, cpsr, exp_cpsr);
    tick();
    check({tag, "_back_to_fetch"}, state, 0);
    check({tag, "_fetch_retired"}, retired, 0);
  endtask

  initial begin
    int rc;
    rst_n    = 1'b0;
    stall    = 1'b0;
    imem_ack = 1'b0;
    op_flags = 7'd0;
    taken    = 1'b0;
    nzcv_in  = 4'd0;
    dmem_ack = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_cpsr", cpsr, 0);
    check("rst_strobes", {ir_load, dmem_req, dmem_we, reg_we, pc_we, retired}, 0);
    #20;
    rst_n = 1'b1;
    #1;
    check("post_rst_req_before_edge", imem_req, 0);
    tick();
    check("post_rst_req_after_edge", imem_req, 1);

    // tag, flags, taken, nzcv, wait, mem, dwe, rwe, wsel, psel, cpsr
    do_instr("alu",     7'b0000001, 1'b0, 4'h6, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);
    do_instr("cmp",     7'b0000010, 1'b0, 4'h9, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h9);
    do_instr("jmp_t",   7'b0000100, 1'b1, 4'hF, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 32'h9);
    do_instr("jmp_nt",  7'b0000100, 1'b0, 4'hF, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h9);
    do_instr("ld",      7'b0001000, 1'b0, 4'hF, 3, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 32'h9);
    do_instr("ret_pri", 7'b1100001, 1'b0, 4'hF, 0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 32'h9);
    do_instr("call",    7'b0100000, 1'b0, 4'hF, 1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 32'h9);
    do_instr("str_pri", 7'b0011000, 1'b1, 4'hF, 0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h9);
    do_instr("nop",     7'b0000000, 1'b1, 4'hF, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h9);

    // Stall in FETCH with the ack already high.
    stall    = 1'b1;
    imem_ack = 1'b1;
    #1;
    check("stall_imem_req", imem_req, 0);
    check("stall_ir_load0", ir_load, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_state", state, 0);
      check("stall_ir_load", ir_load, 0);
    end
    stall = 1'b0;
    do_instr("after_stall", 7'b0000001, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h9);

    // Reset while a str sits in MEM.
    imem_ack = 1'b1;
    op_flags = 7'b0010000;
    #1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    check("abort_mem_state", state, 3);
    check("abort_dmem_req_pre", dmem_req, 1);
    check("abort_dmem_we_pre", dmem_we, 1);
    rc = retire_cnt;
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_dmem_req", dmem_req, 0);
    check("abort_dmem_we", dmem_we, 0);
    check("abort_state", state, 0);
    check("abort_cpsr", cpsr, 0);
    dmem_ack = 1'b1;
    stall    = 1'b1;
    tick();
    tick();
    dmem_ack = 1'b0;
    check("abort_no_retire", retire_cnt, rc);
    #3;
    rst_n = 1'b1;
    tick();
    check("rst_stall_no_req", imem_req, 0);
    check("rst_stall_retire", retire_cnt, rc);
    stall = 1'b0;
    #1;
    check("rst_unstall_req", imem_req, 1);
    do_instr("recover", 7'b0000001, 1'b0, 4'h3, 0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
